set_compare_unit: RTL and testbench

SET_COMPARE_UNIT -- requirements
Module: set_compare_unit

---
 rtl/set_ops_pkg.sv | 62 ++++++
 rtl/set_slice_cmp.sv | 27 ++
 rtl/set_compare_unit.sv | 119 +++++++++++
 tb/tb_set_compare_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_ops_pkg.sv
// Shared opcode constants, FSM state type and op decode
// helpers for the set-compare unit.
package set_ops_pkg;

  localparam logic [3:0] OP_SEQ  = 4'd0;
  localparam logic [3:0] OP_SNE  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SGT  = 4'd3;
  localparam logic [3:0] OP_SLE  = 4'd4;
  localparam logic [3:0] OP_SGE  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SGTU = 4'd7;
  localparam logic [3:0] OP_SLEU = 4'd8;
  localparam logic [3:0] OP_SGEU = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OPC_UNS,
    OPC_SGN,
    OPC_ILL
  } op_class_t;

  function automatic op_class_t op_class(
    input logic [3:0] op
  );
    op_class_t c;
    c = OPC_ILL;
    unique case (1'b1)
      (op >= OP_SLT && op <= OP_SGE): c = OPC_SGN;
      (op < OP_SLT):                  c = OPC_UNS;
      (op >= OP_SLTU && op <= OP_SGEU): c = OPC_UNS;
      (op > OP_SGEU):                 c = OPC_ILL;
    endcase
    return c;
  endfunction

  function automatic logic set_flag(
    input logic [3:0] op,
    input logic       lt,
    input logic       gt,
    input logic       eq
  );
    logic f;
    f = 1'b0;
    unique case (op)
      OP_SEQ:           f = eq;
      OP_SNE:           f = !eq;
      OP_SLT, OP_SLTU:  f = lt;
      OP_SGT, OP_SGTU:  f = gt;
      OP_SLE, OP_SLEU:  f = !gt;
      OP_SGE, OP_SGEU:  f = !lt;
      default:          f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/set_slice_cmp.sv
// Combinational compare of one operand slice; flipping the
// msb turns an unsigned compare into a signed one.
module set_slice_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] sa,
  input  logic [CHUNK-1:0] sb,
  input  logic             invert_msb,
  output logic             s_lt,
  output logic             s_eq
);

  logic [CHUNK-1:0] msk;
  logic [CHUNK-1:0] ua;
  logic [CHUNK-1:0] ub;

  always_comb begin
    msk = '0;
    msk[CHUNK-1] = invert_msb;
  end

  assign ua   = sa ^ msk;
  assign ub   = sb ^ msk;
  assign s_lt = ua < ub;
  assign s_eq = ua == ub;

endmodule

// File: rtl/set_compare_unit.sv
// Multi-cycle set-compare: one CHUNK slice per cycle,
// MSB slice first, stopping at the first difference.
module set_compare_unit
  import set_ops_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal_op
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] TOP = IW'(N - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0 || N < 1) begin : g_bad
    $error("set_compare_unit: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic [IW-1:0]    idx_q;

  logic [CHUNK-1:0] a_sl [N];
  logic [CHUNK-1:0] b_sl [N];

  for (genvar g = 0; g < N; g++) begin : g_sl
    assign a_sl[g] = a_q[g*CHUNK +: CHUNK];
    assign b_sl[g] = b_q[g*CHUNK +: CHUNK];
  end

  op_class_t cls;
  logic      ill;
  logic      inv;
  logic      s_lt;
  logic      s_eq;
  logic      accept;
  logic      finish;
  logic      flag;

  assign cls = op_class(op_q);
  assign ill = (cls == OPC_ILL);
  assign inv = (cls == OPC_SGN) && (idx_q == TOP);

  set_slice_cmp #(
    .CHUNK(CHUNK)
  ) u_cmp (
    .sa        (a_sl[idx_q]),
    .sb        (b_sl[idx_q]),
    .invert_msb(inv),
    .s_lt      (s_lt),
    .s_eq      (s_eq)
  );

  assign accept = (state_q == IDLE) && in_valid;
  assign finish = (state_q == BUSY) &&
                  (ill || !s_eq || idx_q == '0);
  // illegal ops finish on their first busy cycle with flag 0
  assign flag   = !ill &&
                  set_flag(op_q, s_lt, !s_lt && !s_eq, s_eq);

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (finish)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      idx_q      <= TOP;
      result     <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        idx_q <= TOP;
      end
      if (state_q == BUSY) begin
        if (finish) begin
          result     <= WIDTH'(flag);
          illegal_op <= ill;
        end else begin
          idx_q <= idx_q - IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_set_compare_unit.sv
// Self-checking bench for set_compare_unit: directed cases
// plus randomized traffic against a behavioural model.
module tb_set_compare_unit;

  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          illegal_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  set_compare_unit #(
    .WIDTH(W),
    .CHUNK(C)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal_op(illegal_op)
  );

  function automatic logic [W-1:0] ref_result(
    input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y
  );
    logic lt, gt, eq, s;
    if (o >= 4'd2 && o <= 4'd5) begin
      lt = $signed(x) < $signed(y);
      gt = $signed(x) > $signed(y);
    end else begin
      lt = x < y;
      gt = x > y;
    end
    eq = (x == y);
    case (o)
      4'd0:       s = eq;
      4'd1:       s = !eq;
      4'd2, 4'd6: s = lt;
      4'd3, 4'd7: s = gt;
      4'd4, 4'd8: s = !gt;
      4'd5, 4'd9: s = !lt;
      default:    s = 1'b0;
    endcase
    return W'(s);
  endfunction

  function automatic int ref_k(
    input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y
  );
    logic [W-1:0] d;
    if (o > 4'd9) return 1;
    d = x ^ y;
    for (int i = W - 1; i >= 0; i--)
      if (d[i]) return N - i / C;
    return N;
  endfunction

  // call #1 after a posedge; returns when out_valid is seen
  task automatic do_req(
    input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
    output int k, output logic [W-1:0] r, output logic il
  );
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=%0b need 1", in_ready);
    end
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!out_valid && k < 50);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout out_valid=0 need 1");
    end
    r = result; il = illegal_op;
  endtask

  task automatic release_resp();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready got %b need 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got %b need 0", out_valid);
    end
    checks++;
    if (result !== '0) begin
      errors++; $display("FAIL rst_result got %h need 0", result);
    end
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++; $display("FAIL rst_illegal got %b need 0", illegal_op);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_release_ready got %b need 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [3:0]   t_op [5] = '{4'd2, 4'd6, 4'd0, 4'd5, 4'd3};
    logic [W-1:0] t_a  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h12345678, 32'h00000100, 32'h0BADF00D};
    logic [W-1:0] t_b  [5] = '{32'h00000001, 32'h00000001,
                              32'h12345678, 32'h000000FF, 32'h0BADF00D};
    logic [W-1:0] t_r  [5] = '{32'h1, 32'h0, 32'h1, 32'h1, 32'h0};
    int           t_k  [5] = '{1, 1, 4, 3, 4};
    int k; logic [W-1:0] r; logic il;
    for (int i = 0; i < 5; i++) begin
      do_req(t_op[i], t_a[i], t_b[i], k, r, il);
      checks++;
      if (r !== t_r[i]) begin
        errors++; $display("FAIL dir_result[%0d] got %h need %h", i, r, t_r[i]);
      end
      checks++;
      if (k !== t_k[i]) begin
        errors++; $display("FAIL dir_latency[%0d] got %0d need %0d", i, k, t_k[i]);
      end
      checks++;
      if (il !== 1'b0) begin
        errors++; $display("FAIL dir_illegal[%0d] got %b need 0", i, il);
      end
      release_resp();
    end
  endtask

  task automatic test_hold();
    int k; logic [W-1:0] r; logic il;
    do_req(4'd4, 32'h80000000, 32'h7FFFFFFF, k, r, il);
    checks++;
    if (r !== 32'h1 || k !== 1) begin
      errors++; $display("FAIL hold_first got r=%h k=%0d need r=1 k=1", r, k);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== r ||
          illegal_op !== il || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d] got v=%b r=%h il=%b rdy=%b need v=1 r=%h il=%b rdy=0",
                 i, out_valid, result, illegal_op, in_ready, r, il);
      end
    end
    release_resp();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release got v=%b rdy=%b need v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_busy();
    int k; logic [W-1:0] r; logic il;
    int seen;
    do_req(4'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, k, r, il);
    release_resp();
    checks++;
    if (result !== 32'h1) begin
      errors++; $display("FAIL rb_pre_result got %h need 1", result);
    end
    in_valid = 1'b1; op = 4'd0; a = 32'h5A5A5A5A; b = 32'h5A5A5A5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 ||
        illegal_op !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rb_reset got v=%b r=%h il=%b rdy=%b need 0 0 0 0",
               out_valid, result, illegal_op, in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rb_idle got rdy=%b need 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rb_no_resp got %0d valid cycles need 0", seen);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [3] = '{4'hC, 4'hA, 4'hF};
    int k; logic [W-1:0] r; logic il;
    for (int i = 0; i < 3; i++) begin
      do_req(ops[i], $urandom, $urandom, k, r, il);
      checks++;
      if (il !== 1'b1 || r !== '0 || k !== 1) begin
        errors++;
        $display("FAIL ill_op[%0d] got il=%b r=%h k=%0d need il=1 r=0 k=1",
                 i, il, r, k);
      end
      release_resp();
      do_req(4'd0, 32'h00C0FFEE, 32'h00C0FFEE, k, r, il);
      checks++;
      if (il !== 1'b0 || r !== 32'h1) begin
        errors++;
        $display("FAIL ill_clear[%0d] got il=%b r=%h need il=0 r=1", i, il, r);
      end
      release_resp();
    end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int e;
    e = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; op = 4'd6; a = 32'h00010000; b = 32'h00020000;
    while (acc.size() < 3 && e < 60) begin
      if (in_ready) acc.push_back(e + 1);
      @(posedge clk); #1; e++;
    end
    in_valid = 1'b0;
    e = 0;
    while (!in_ready && e < 20) begin
      @(posedge clk); #1; e++;
    end
    out_ready = 1'b0;
    checks++;
    if (acc.size() != 3) begin
      errors++; $display("FAIL b2b_count got %0d need 3", acc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc[i] - acc[i-1] != 4) begin
          errors++;
          $display("FAIL b2b_gap[%0d] got %0d need 4", i, acc[i] - acc[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    int k; logic [W-1:0] r; logic il;
    logic [3:0] o; logic [W-1:0] x, y;
    int hold;
    for (int n = 0; n < 300; n++) begin
      o = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                       : 4'($urandom_range(0, 9));
      x = $urandom;
      y = x;
      for (int s = 0; s < N; s++)
        if ($urandom_range(0, 3) == 0) y[s*C +: C] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) y = $urandom;
      do_req(o, x, y, k, r, il);
      checks++;
      if (r !== ref_result(o, x, y) || il !== (o > 4'd9) ||
          k !== ref_k(o, x, y)) begin
        errors++;
        $display("FAIL rnd[%0d] op=%0d a=%h b=%h got r=%h il=%b k=%0d need r=%h il=%b k=%0d",
                 n, o, x, y, r, il, k, ref_result(o, x, y), o > 4'd9, ref_k(o, x, y));
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || result !== r || illegal_op !== il) begin
          errors++;
          $display("FAIL rnd_hold[%0d] got v=%b r=%h need v=1 r=%h", n, out_valid, result, r);
        end
      end
      release_resp();
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_busy();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
